// File: rtl/time_keeper.sv
// Real-time clock: hours/minutes/seconds kept from a clk prescaler, with a
// four-state button FSM (RUN, SET_H, SET_M, SET_S) for setting the time.
module time_keeper #(
    parameter int CLK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hours_disp,
    output logic [7:0] min_disp,
    output logic [7:0] sec_disp,
    output logic [1:0] set_mode,
    output logic       sec_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          mode_prev_q, mode_prev_d;
    logic          inc_prev_q, inc_prev_d;
    logic          sec_tick_q, sec_tick_d;

    logic          mode_press;
    logic          inc_press;
    logic          tick;
    logic          sel_h, sel_m, sel_s;

    // A press is the first cycle a button is seen high; mode wins over inc.
    assign mode_press = mode_btn & ~mode_prev_q;
    assign inc_press  = inc_btn & ~inc_prev_q & ~mode_press;
    assign tick       = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        sel_h = (state_q == SET_H);
        sel_m = (state_q == SET_M);
        sel_s = (state_q == SET_S);
    end

    // Prescaler only runs while staying in RUN, so re-entering RUN restarts
    // a full second.
    always_comb begin
        presc_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        hours_d     = hours_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_tick_d  = 1'b0;
        mode_prev_d = mode_btn;
        inc_prev_d  = inc_btn;
        if (tick) begin
            sec_tick_d = 1'b1;
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d   = 6'd0;
                    hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (inc_press) begin
            if (sel_h) begin
                hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end
            if (sel_m) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
            if (sel_s) begin
                sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            hours_q     <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            sec_tick_q  <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hours_q     <= hours_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
            sec_tick_q  <= sec_tick_d;
        end
    end

    assign hours_disp = {3'b000, hours_q};
    assign min_disp   = {2'b00, min_q};
    assign sec_disp   = {2'b00, sec_q};
    assign set_mode   = state_q;
    assign sec_tick   = sec_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios with literal expectations plus
// random button traffic, all checked every cycle against a seconds-of-day model.
module tb_time_keeper;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [7:0] hours_disp, min_disp, sec_disp;
    logic [1:0] set_mode;
    logic       sec_tick;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cycle = 0;
    bit chk_en = 1'b0;

    // Behavioural model: mode index, cycles spent in RUN, and a time of day.
    int  m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_cnt = 0, m_tick = 0;
    bit  m_mprev = 1'b0, m_iprev = 1'b0;

    time_keeper #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .hours_disp(hours_disp),
        .min_disp  (min_disp),
        .sec_disp  (sec_disp),
        .set_mode  (set_mode),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    // Model advances on every rising edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        bit mp, ip;
        int tod;
        cycle++;
        if (reset) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_cnt = 0; m_tick = 0;
            m_mprev = 1'b0; m_iprev = 1'b0;
        end else begin
            mp = mode_btn && !m_mprev;
            ip = inc_btn && !m_iprev && !mp;
            m_tick = 0;
            if (m_mode == 0) begin
                m_cnt++;
                if (m_cnt == CLK_DIV) begin
                    m_cnt = 0;
                    tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = tod / 3600;
                    m_m = (tod / 60) % 60;
                    m_s = tod % 60;
                    m_tick = 1;
                end
            end else if (ip) begin
                case (m_mode)
                    1: m_h = (m_h + 1) % 24;
                    2: m_m = (m_m + 1) % 60;
                    default: m_s = (m_s + 1) % 60;
                endcase
            end
            if (mp) begin
                m_mode = (m_mode + 1) % 4;
                m_cnt = 0;
            end
            m_mprev = mode_btn;
            m_iprev = inc_btn;
        end
    end

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [26:0] got, exp;
        if (chk_en) begin
            got = {hours_disp, min_disp, sec_disp, set_mode, sec_tick};
            exp = {8'(m_h), 8'(m_m), 8'(m_s), 2'(m_mode), 1'(m_tick)};
            total_cnt++;
            if (got === exp) pass_cnt++;
            else $display("[TB] FAIL model_cmp cycle %0d: got h=%0d m=%0d s=%0d mode=%0d tick=%0d, need h=%0d m=%0d s=%0d mode=%0d tick=%0d",
                          cycle, hours_disp, min_disp, sec_disp, set_mode, sec_tick,
                          m_h, m_m, m_s, m_mode, m_tick);
        end
    end

    task automatic applyStimulus(input bit m, input bit i, input bit r, input int n);
        mode_btn = m;
        inc_btn  = i;
        reset    = r;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit i);
        applyStimulus(m, i, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic incN(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input int h, input int m, input int s,
                               input int md, input int tk);
        logic [26:0] exp, got, mdl;
        exp = {8'(h), 8'(m), 8'(s), 2'(md), 1'(tk)};
        got = {hours_disp, min_disp, sec_disp, set_mode, sec_tick};
        mdl = {8'(m_h), 8'(m_m), 8'(m_s), 2'(m_mode), 1'(m_tick)};
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got h=%0d m=%0d s=%0d mode=%0d tick=%0d, need h=%0d m=%0d s=%0d mode=%0d tick=%0d",
                      name, hours_disp, min_disp, sec_disp, set_mode, sec_tick, h, m, s, md, tk);
        total_cnt++;
        if (mdl === exp) pass_cnt++;
        else $display("[TB] FAIL model_%s: model h=%0d m=%0d s=%0d mode=%0d tick=%0d, need h=%0d m=%0d s=%0d mode=%0d tick=%0d",
                      name, m_h, m_m, m_s, m_mode, m_tick, h, m, s, md, tk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        doReset();
        checkOutput("reset_state", 0, 0, 0, 0, 0);
        chk_en = 1'b1;

        // Free running seconds at CLK_DIV spacing.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 3);
            checkOutput($sformatf("run_pre%0d", k), 0, 0, k - 1, 0, 0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            checkOutput($sformatf("run_tick%0d", k), 0, 0, k, 0, 1);
        end

        // Simultaneous mode+inc, then a held inc counts once.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("mode_inc_same", 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("inc_held", 1, 0, 0, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);

        // 25 hour increments wrap to 1.
        doReset();
        press(1'b1, 1'b0);
        incN(25);
        checkOutput("hours_wrap25", 1, 0, 0, 1, 0);

        // Preload 23:59:59 and roll over.
        incN(22);
        press(1'b1, 1'b0);
        incN(59);
        press(1'b1, 1'b0);
        incN(59);
        checkOutput("preload", 23, 59, 59, 3, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("back_to_run", 23, 59, 59, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("rollover_pre", 23, 59, 59, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("rollover", 0, 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("tick_one_cycle", 0, 0, 0, 0, 0);

        // Minute wrap in SET_M leaves hours alone.
        doReset();
        press(1'b1, 1'b0);
        incN(5);
        press(1'b1, 1'b0);
        incN(59);
        checkOutput("min59", 5, 59, 0, 2, 0);
        incN(1);
        checkOutput("min_wrap", 5, 0, 0, 2, 0);

        // Reset in SET_S discards the edit.
        doReset();
        press(1'b1, 1'b0);
        incN(12);
        press(1'b1, 1'b0);
        incN(34);
        press(1'b1, 1'b0);
        incN(56);
        checkOutput("set_12_34_56", 12, 34, 56, 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("reset_in_set", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        checkOutput("post_reset_pre", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("post_reset_tick", 0, 0, 1, 0, 1);

        // Random button traffic with occasional reset.
        for (int c = 0; c < 4000; c++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 149) == 0, 1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
